// File: rtl/if_id_stage_pkg.sv
// Shared LC-3b pipeline types used by the fetch/decode boundary.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word ir;
  } lc3b_fetch_entry;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } lc3b_if_state;

endpackage

// File: rtl/if_id_stage_fetch_fifo.sv
// Circular buffer of fetched {pc, ir} entries; head is read straight from storage.
module fetch_fifo
  import lc3b_types::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  lc3b_fetch_entry push_data,
  input  logic            pop,
  input  logic            clear,
  output logic [AW:0]     count,
  output logic            empty,
  output logic            full,
  output lc3b_fetch_entry head
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  lc3b_fetch_entry mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;
  logic            do_push_s;
  logic            do_pop_s;

  assign empty = (count_r == '0);
  assign full  = (count_r == DEPTH_W);
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // clear dominates; a pop on empty or a push on full is ignored
  assign do_push_s = push && !full && !clear;
  assign do_pop_s  = pop && !empty && !clear;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // entry storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// LC-3b fetch-to-decode stage: issues imem reads, buffers returned words, feeds decode.
module if_id_stage
  import lc3b_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset_n,
  input  lc3b_word pc_in,
  input  lc3b_word imem_rdata,
  input  logic     imem_resp,
  output logic     imem_read,
  output lc3b_word imem_address,
  output logic     load_pc,
  input  logic     flush,
  input  logic     id_ready,
  output logic     valid_out,
  output lc3b_word ir_out,
  output lc3b_word pc_out
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  lc3b_if_state    state_r;
  lc3b_if_state    state_next_s;
  logic            imem_read_r;
  logic            imem_read_next_s;
  lc3b_word        imem_address_r;
  lc3b_word        imem_address_next_s;
  logic            push_s;
  logic            pop_s;
  logic [AW:0]     count_s;
  logic            empty_s;
  logic            full_s;
  lc3b_fetch_entry push_data_s;
  lc3b_fetch_entry head_s;

  assign imem_read    = imem_read_r;
  assign imem_address = imem_address_r;
  assign valid_out    = !empty_s;
  assign ir_out       = head_s.ir;
  assign pc_out       = head_s.pc;
  assign pop_s        = valid_out && id_ready && !flush;
  assign push_data_s  = '{pc: imem_address_r, ir: imem_rdata};

  // flush term lets the fetch stage capture its redirect target
  assign load_pc = ((state_r == BUSY) && imem_resp && !flush) || flush;

  // state and request registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      imem_read_r    <= 1'b0;
      imem_address_r <= 16'h0000;
    end else begin
      state_r        <= state_next_s;
      imem_read_r    <= imem_read_next_s;
      imem_address_r <= imem_address_next_s;
    end
  end

  // next-state and request control; requests only go out with a free slot reserved
  always_comb begin
    state_next_s        = state_r;
    imem_read_next_s    = imem_read_r;
    imem_address_next_s = imem_address_r;
    push_s              = 1'b0;
    case (state_r)
      IDLE: begin
        if (!flush && (count_s < DEPTH_W)) begin
          state_next_s        = BUSY;
          imem_read_next_s    = 1'b1;
          imem_address_next_s = pc_in;
        end else begin
          imem_read_next_s = 1'b0;
        end
      end
      BUSY: begin
        if (imem_resp) begin
          push_s           = !flush;
          state_next_s     = IDLE;
          imem_read_next_s = 1'b0;
        end else if (flush) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = BUSY;
        end
      end
      DRAIN: begin
        if (imem_resp) begin
          state_next_s     = IDLE;
          imem_read_next_s = 1'b0;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: begin
        state_next_s     = IDLE;
        imem_read_next_s = 1'b0;
      end
    endcase
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_s),
    .push_data(push_data_s),
    .pop      (pop_s),
    .clear    (flush),
    .count    (count_s),
    .empty    (empty_s),
    .full     (full_s),
    .head     (head_s)
  );

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with a scoreboard queue checked by an independent monitor.
module tb_if_id_stage;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     reset_n;
  lc3b_word pc_in;
  lc3b_word imem_rdata;
  logic     imem_resp;
  logic     imem_read;
  lc3b_word imem_address;
  logic     load_pc;
  logic     flush;
  logic     id_ready;
  logic     valid_out;
  lc3b_word ir_out;
  lc3b_word pc_out;

  int vectors = 0;
  int miscompares = 0;
  lc3b_fetch_entry exp_q[$];

  if_id_stage #(.DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .imem_read(imem_read), .imem_address(imem_address),
    .load_pc(load_pc), .flush(flush), .id_ready(id_ready), .valid_out(valid_out),
    .ir_out(ir_out), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every pop decode performs must match the oldest expected entry
  always @(negedge clk) begin
    if (reset_n) begin
      if (flush) begin
        exp_q.delete();
      end else if (valid_out && id_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL pop_unexpected: got pc=%h ir=%h expected no entry", pc_out, ir_out);
        end else begin
          lc3b_fetch_entry e;
          e = exp_q.pop_front();
          if (pc_out !== e.pc || ir_out !== e.ir) begin
            miscompares++;
            $display("FAIL pop_data: got pc=%h ir=%h expected pc=%h ir=%h",
                     pc_out, ir_out, e.pc, e.ir);
          end
        end
      end
    end
  end

  // wait (bounded) for a request, then check its address
  task automatic wait_issue(input logic [15:0] exp_pc);
    int k;
    for (k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (imem_read) break;
    end
    check("issue_read", {15'd0, imem_read}, 16'h0001);
    check("issue_addr", imem_address, exp_pc);
  endtask

  // mode: 0 normal, 1 flush with resp, 2 drain resp, 3 pop together with push
  task automatic fetch(input logic [15:0] exp_pc, input logic [15:0] data, input int n,
                       input int mode, input logic [15:0] next_pc);
    lc3b_fetch_entry e;
    wait_issue(exp_pc);
    repeat (n - 1) begin
      @(posedge clk); #1;
    end
    imem_resp  = 1'b1;
    imem_rdata = data;
    if (mode == 1) flush = 1'b1;
    if (mode == 3) id_ready = 1'b1;
    #1;
    check("load_pc_resp", {15'd0, load_pc}, (mode == 2) ? 16'h0000 : 16'h0001);
    if (mode == 0 || mode == 3) begin
      e.pc = exp_pc;
      e.ir = data;
      exp_q.push_back(e);
    end
    pc_in = next_pc;
    @(posedge clk); #1;
    imem_resp = 1'b0;
    flush     = 1'b0;
    if (mode == 3) id_ready = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    pc_in      = 16'h0000;
    imem_rdata = 16'h0000;
    imem_resp  = 1'b1;
    flush      = 1'b0;
    id_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read", {15'd0, imem_read}, 16'h0000);
    check("rst_addr", imem_address, 16'h0000);
    check("rst_load_pc", {15'd0, load_pc}, 16'h0000);
    check("rst_valid", {15'd0, valid_out}, 16'h0000);
    check("rst_ir", ir_out, 16'h0000);
    check("rst_pc", pc_out, 16'h0000);

    imem_resp = 1'b0;
    reset_n   = 1'b1;
    @(posedge clk); #1;
    check("first_read", {15'd0, imem_read}, 16'h0001);
    check("first_addr", imem_address, 16'h0000);

    // single fetch, then decode stall fills both entries
    fetch(16'h0000, 16'h1234, 2, 0, 16'h0002);
    check("single_valid", {15'd0, valid_out}, 16'h0001);
    check("single_ir", ir_out, 16'h1234);
    check("single_pc", pc_out, 16'h0000);
    fetch(16'h0002, 16'h5678, 2, 0, 16'h0004);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("full_no_read", {15'd0, imem_read}, 16'h0000);
    end
    id_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    id_ready = 1'b0;
    check("drained_valid", {15'd0, valid_out}, 16'h0000);

    // refill, pop one, then flush while the next fetch is in flight
    fetch(16'h0004, 16'h2222, 2, 0, 16'h0006);
    fetch(16'h0006, 16'h3333, 2, 0, 16'h0008);
    id_ready = 1'b1;
    @(posedge clk); #1;
    id_ready = 1'b0;
    wait_issue(16'h0008);
    flush = 1'b1;
    pc_in = 16'h0100;
    #1;
    check("flush_load_pc", {15'd0, load_pc}, 16'h0001);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_valid", {15'd0, valid_out}, 16'h0000);
    check("drain_read", {15'd0, imem_read}, 16'h0001);
    check("drain_addr", imem_address, 16'h0008);
    id_ready = 1'b1;
    fetch(16'h0008, 16'hDEAD, 1, 2, 16'h0100);
    check("drain_no_push", {15'd0, valid_out}, 16'h0000);

    // flush coincident with response
    fetch(16'h0100, 16'hBEEF, 2, 1, 16'h0200);
    check("flush_resp_valid", {15'd0, valid_out}, 16'h0000);

    // pop and push in the same cycle keeps one entry
    id_ready = 1'b0;
    fetch(16'h0200, 16'hA0A0, 2, 0, 16'h0202);
    fetch(16'h0202, 16'hB0B0, 3, 3, 16'h0204);
    check("pp_valid", {15'd0, valid_out}, 16'h0001);
    check("pp_pc", pc_out, 16'h0202);
    check("pp_ir", ir_out, 16'hB0B0);

    // pointer wrap, order preserved through the monitor
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fetch(16'h0204 + 16'(2 * i), 16'hC000 + 16'(i), 2, 0, 16'h0206 + 16'(2 * i));
    end

    // async reset in the middle of a request
    wait_issue(16'h020E);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_read", {15'd0, imem_read}, 16'h0000);
    check("arst_valid", {15'd0, valid_out}, 16'h0000);
    exp_q.delete();
    @(posedge clk); #1;
    imem_resp  = 1'b1;
    imem_rdata = 16'h7777;
    reset_n    = 1'b1;
    @(posedge clk); #1;
    imem_resp = 1'b0;
    @(posedge clk); #1;
    check("stray_valid", {15'd0, valid_out}, 16'h0000);
    fetch(16'h020E, 16'hF00D, 1, 0, 16'h0210);
    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", 16'(exp_q.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
